muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide execution unit. Consumes the two operands read from the register file. Produces a writeback triple (destination register, data, write flag) that feeds the register file write port. Uses radix-2 iteration: one bit per cycle, one operation in flight.

---
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide execution unit.
// Radix-2 iteration (one bit per cycle), one operation in flight.
// Ports:
//   clk_w_i          clock, all state changes on posedge
//   res_w_i_l        asynchronous active-low reset
//   start_w_i        request, sampled only in IDLE
//   kill_w_i         synchronous abort of an in-flight op
//   op_w_i           RV32M funct3 (MUL..REMU)
//   src_a_w_i        rs1 data
//   src_b_w_i        rs2 data
//   rd_w_i           destination register index
//   busy_w_o         high whenever not IDLE
//   done_w_o         one-cycle completion pulse
//   result_w_o       result, held until the next accepted start
//   wr_reg_w_o       captured rd (register file write address)
//   wr_data_w_o      same value as result_w_o
//   reg_wr_flag_w_o  done pulse qualified by rd != 0
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_w_i,
   input  logic            res_w_i_l,
   input  logic            start_w_i,
   input  logic            kill_w_i,
   input  logic [2:0]      op_w_i,
   input  logic [XLEN-1:0] src_a_w_i,
   input  logic [XLEN-1:0] src_b_w_i,
   input  logic [4:0]      rd_w_i,
   output logic            busy_w_o,
   output logic            done_w_o,
   output logic [XLEN-1:0] result_w_o,
   output logic [4:0]      wr_reg_w_o,
   output logic [XLEN-1:0] wr_data_w_o,
   output logic            reg_wr_flag_w_o
);

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state;
   logic [2:0]        op_q;
   logic [XLEN-1:0]   a_mag_q;
   logic [XLEN-1:0]   b_mag_q;
   logic [2*XLEN-1:0] acc;
   logic [5:0]        iter;
   logic              neg_res_q;
   logic              a_neg_q;
   logic              special_q;

   // Operand decode at capture: signedness per funct3, magnitudes, and the
   // divide corner cases that bypass the iteration entirely.
   logic            signed_a, signed_b, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] special_val;

   always_comb begin
      signed_a    = (op_w_i == 3'd1) || (op_w_i == 3'd2) || (op_w_i == 3'd4) || (op_w_i == 3'd6);
      signed_b    = (op_w_i == 3'd1) || (op_w_i == 3'd4) || (op_w_i == 3'd6);
      a_neg       = signed_a && src_a_w_i[XLEN-1];
      b_neg       = signed_b && src_b_w_i[XLEN-1];
      a_mag       = a_neg ? -src_a_w_i : src_a_w_i;
      b_mag       = b_neg ? -src_b_w_i : src_b_w_i;
      div_zero    = op_w_i[2] && (src_b_w_i == '0);
      div_ovf     = op_w_i[2] && !op_w_i[0] && (src_a_w_i == MIN_VAL) && (src_b_w_i == '1);
      special_val = '0;
      if (div_zero)
         special_val = op_w_i[1] ? src_a_w_i : '1;
      else if (div_ovf)
         special_val = op_w_i[1] ? '0 : MIN_VAL;
   end

   // One radix-2 step. Multiply: acc holds {partial high, multiplier}; add the
   // multiplicand when the multiplier LSB is set, then shift right.
   // Divide: acc holds {remainder, dividend/quotient}; shift left one bit and
   // subtract the divisor when it fits (restoring).
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN+1:0]   div_diff;
   logic [2*XLEN-1:0] step_next;

   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? a_mag_q : {XLEN{1'b0}})};
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, b_mag_q};
      if (op_q[2]) begin
         if (div_diff[XLEN+1])
            step_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         else
            step_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
         step_next = {mul_sum, acc[XLEN-1:1]};
      end
   end

   // Sign fix-up and result selection. Quotient/product take the XOR of the
   // operand signs; the remainder follows the dividend.
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, fix_result;

   always_comb begin
      prod = neg_res_q ? -acc : acc;
      quo  = neg_res_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = a_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op_q)
         3'd0:       fix_result = prod[XLEN-1:0];
         3'd4, 3'd5: fix_result = quo;
         3'd6, 3'd7: fix_result = rem;
         default:    fix_result = prod[2*XLEN-1:XLEN];
      endcase
      if (special_q)
         fix_result = acc[XLEN-1:0];
   end

   // Control FSM with registered outputs. Special divide cases go straight
   // to FIX with the answer preloaded into acc, which gives them a one-cycle
   // latency while sharing the same DONE/writeback path.
   always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
      if (!res_w_i_l) begin
         state           <= IDLE;
         op_q            <= '0;
         a_mag_q         <= '0;
         b_mag_q         <= '0;
         acc             <= '0;
         iter            <= '0;
         neg_res_q       <= 1'b0;
         a_neg_q         <= 1'b0;
         special_q       <= 1'b0;
         done_w_o        <= 1'b0;
         reg_wr_flag_w_o <= 1'b0;
         result_w_o      <= '0;
         wr_reg_w_o      <= '0;
      end else begin
         done_w_o        <= 1'b0;
         reg_wr_flag_w_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_w_i && !kill_w_i) begin
                  op_q       <= op_w_i;
                  a_mag_q    <= a_mag;
                  b_mag_q    <= b_mag;
                  neg_res_q  <= a_neg ^ b_neg;
                  a_neg_q    <= a_neg;
                  wr_reg_w_o <= rd_w_i;
                  result_w_o <= '0;
                  iter       <= '0;
                  if (div_zero || div_ovf) begin
                     special_q <= 1'b1;
                     acc       <= {{XLEN{1'b0}}, special_val};
                     state     <= FIX;
                  end else begin
                     special_q <= 1'b0;
                     acc       <= {{XLEN{1'b0}}, (op_w_i[2] ? a_mag : b_mag)};
                     state     <= CALC;
                  end
               end
            end
            CALC: begin
               if (kill_w_i) begin
                  state <= IDLE;
               end else begin
                  acc  <= step_next;
                  iter <= iter + 6'd1;
                  if (iter == 6'(XLEN-1))
                     state <= FIX;
               end
            end
            FIX: begin
               if (kill_w_i) begin
                  state <= IDLE;
               end else begin
                  result_w_o      <= fix_result;
                  done_w_o        <= 1'b1;
                  reg_wr_flag_w_o <= (wr_reg_w_o != 5'd0);
                  state           <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy_w_o    = (state != IDLE);
   assign wr_data_w_o = result_w_o;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// Expected writebacks are pushed to a scoreboard queue when an op is issued
// and popped when the DUT pulses done.
module tb_muldiv_unit;

   logic        clk_w_i;
   logic        res_w_i_l;
   logic        start_w_i;
   logic        kill_w_i;
   logic [2:0]  op_w_i;
   logic [31:0] src_a_w_i;
   logic [31:0] src_b_w_i;
   logic [4:0]  rd_w_i;
   logic        busy_w_o;
   logic        done_w_o;
   logic [31:0] result_w_o;
   logic [4:0]  wr_reg_w_o;
   logic [31:0] wr_data_w_o;
   logic        reg_wr_flag_w_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        flag;
   } exp_t;

   exp_t sb[$];

   muldiv_unit #(.XLEN(32)) dut (
      .clk_w_i         (clk_w_i),
      .res_w_i_l       (res_w_i_l),
      .start_w_i       (start_w_i),
      .kill_w_i        (kill_w_i),
      .op_w_i          (op_w_i),
      .src_a_w_i       (src_a_w_i),
      .src_b_w_i       (src_b_w_i),
      .rd_w_i          (rd_w_i),
      .busy_w_o        (busy_w_o),
      .done_w_o        (done_w_o),
      .result_w_o      (result_w_o),
      .wr_reg_w_o      (wr_reg_w_o),
      .wr_data_w_o     (wr_data_w_o),
      .reg_wr_flag_w_o (reg_wr_flag_w_o)
   );

   initial clk_w_i = 1'b0;
   always #5 clk_w_i = ~clk_w_i;

   // Reference model built on 64-bit host arithmetic.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb64, za, zb, p;
      int ia, ib;
      sa   = {{32{a[31]}}, a};
      sb64 = {{32{b[31]}}, b};
      za   = {32'h0, a};
      zb   = {32'h0, b};
      ia   = int'(a);
      ib   = int'(b);
      case (op)
         3'd0: begin p = za * zb;   return p[31:0];  end
         3'd1: begin p = sa * sb64; return p[63:32]; end
         3'd2: begin p = sa * zb;   return p[63:32]; end
         3'd3: begin p = za * zb;   return p[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && (b == 32'h0)) return 1;
      if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Caller sits at a negedge; start is sampled at the next posedge (edge k)
   // and the task returns at the negedge after edge k with operands scrambled.
   task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] expected);
      exp_t e;
      start_w_i = 1'b1;
      op_w_i    = op;
      src_a_w_i = a;
      src_b_w_i = b;
      rd_w_i    = rd;
      e.result  = expected;
      e.rd      = rd;
      e.flag    = (rd != 5'd0);
      sb.push_back(e);
      @(posedge clk_w_i);
      @(negedge clk_w_i);
      start_w_i = 1'b0;
      op_w_i    = 3'($urandom);
      src_a_w_i = $urandom;
      src_b_w_i = $urandom;
      rd_w_i    = 5'($urandom);
   endtask

   // Counts negedges until done is seen; cycles=m means done is high in the
   // interval starting m edges after the call point.
   task automatic wait_done(input int max_cycles, output int cycles, output bit timed_out);
      cycles    = 0;
      timed_out = 1'b0;
      while (done_w_o !== 1'b1) begin
         if (cycles >= max_cycles) begin
            timed_out = 1'b1;
            return;
         end
         @(negedge clk_w_i);
         cycles++;
      end
   endtask

   task automatic test_reset();
      res_w_i_l = 1'b0;
      start_w_i = 1'b0;
      kill_w_i  = 1'b0;
      op_w_i    = 3'd0;
      src_a_w_i = '0;
      src_b_w_i = '0;
      rd_w_i    = '0;
      repeat (2) @(negedge clk_w_i);
      checks++; if (busy_w_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_w_o); end
      checks++; if (done_w_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_w_o); end
      checks++; if (result_w_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result_w_o); end
      checks++; if (wr_reg_w_o !== 5'd0) begin errors++; $display("FAIL reset_wr_reg got %0d want 0", wr_reg_w_o); end
      checks++; if (wr_data_w_o !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data_w_o); end
      checks++; if (reg_wr_flag_w_o !== 1'b0) begin errors++; $display("FAIL reset_flag got %b want 0", reg_wr_flag_w_o); end
      res_w_i_l = 1'b1;
      @(negedge clk_w_i);
      checks++; if (busy_w_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy_w_o); end
   endtask

   // Directed ops: mul family, normal divides, special divides, rd=0.
   task automatic run_table(input string tag, input logic [2:0] ops[], input logic [31:0] as[],
                            input logic [31:0] bs[], input logic [4:0] rds[],
                            input logic [31:0] res[], input int lats[]);
      int  cyc;
      bit  to;
      exp_t e;
      for (int i = 0; i < ops.size(); i++) begin
         apply_stimulus(ops[i], as[i], bs[i], rds[i], res[i]);
         wait_done(40, cyc, to);
         e = sb.pop_front();
         checks++;
         if (to) begin
            errors++; $display("FAIL %s_timeout row %0d no done within 40 cycles", tag, i);
         end else begin
            checks++; if (cyc + 1 !== lats[i] + 1) begin errors++; $display("FAIL %s_latency row %0d got %0d want %0d", tag, i, cyc, lats[i]); end
            checks++; if (result_w_o !== e.result) begin errors++; $display("FAIL %s_result row %0d got %h want %h", tag, i, result_w_o, e.result); end
            checks++; if (wr_data_w_o !== e.result) begin errors++; $display("FAIL %s_wr_data row %0d got %h want %h", tag, i, wr_data_w_o, e.result); end
            checks++; if (wr_reg_w_o !== e.rd) begin errors++; $display("FAIL %s_wr_reg row %0d got %0d want %0d", tag, i, wr_reg_w_o, e.rd); end
            checks++; if (reg_wr_flag_w_o !== e.flag) begin errors++; $display("FAIL %s_flag row %0d got %b want %b", tag, i, reg_wr_flag_w_o, e.flag); end
            @(negedge clk_w_i);
            checks++; if (done_w_o !== 1'b0) begin errors++; $display("FAIL %s_done_width row %0d got %b want 0", tag, i, done_w_o); end
            checks++; if (busy_w_o !== 1'b0) begin errors++; $display("FAIL %s_busy_after row %0d got %b want 0", tag, i, busy_w_o); end
            checks++; if (result_w_o !== e.result) begin errors++; $display("FAIL %s_result_hold row %0d got %h want %h", tag, i, result_w_o, e.result); end
         end
      end
   endtask

   task automatic test_mul();
      logic [2:0]  ops[] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0};
      logic [31:0] as[]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
      logic [31:0] bs[]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd4};
      logic [4:0]  rds[] = '{5'd5, 5'd1, 5'd31, 5'd12, 5'd0};
      logic [31:0] res[] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd12};
      int          lats[] = '{33, 33, 33, 33, 33};
      run_table("mul", ops, as, bs, rds, res, lats);
   endtask

   task automatic test_div();
      logic [2:0]  ops[] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5};
      logic [31:0] as[]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                             32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs[]  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [4:0]  rds[] = '{5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
      logic [31:0] res[] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                             32'h8000_0000, 32'd0, 32'd0};
      int          lats[] = '{33, 33, 33, 33, 1, 1, 1, 1, 33};
      run_table("div", ops, as, bs, rds, res, lats);
   endtask

   task automatic test_ignore_start();
      int   cyc;
      bit   to;
      exp_t e;
      apply_stimulus(3'd5, 32'd100, 32'd7, 5'd3, 32'd14);
      repeat (9) @(negedge clk_w_i);
      start_w_i = 1'b1; op_w_i = 3'd4; src_a_w_i = 32'd5; src_b_w_i = 32'd0; rd_w_i = 5'd7;
      @(negedge clk_w_i);
      start_w_i = 1'b0;
      wait_done(40, cyc, to);
      e = sb.pop_front();
      checks++;
      if (to) begin
         errors++; $display("FAIL ignore_timeout no done within 40 cycles");
      end else begin
         checks++; if (cyc + 10 !== 33) begin errors++; $display("FAIL ignore_latency got %0d want 33", cyc + 10); end
         checks++; if (result_w_o !== e.result) begin errors++; $display("FAIL ignore_result got %h want %h", result_w_o, e.result); end
         checks++; if (wr_reg_w_o !== e.rd) begin errors++; $display("FAIL ignore_wr_reg got %0d want %0d", wr_reg_w_o, e.rd); end
         @(negedge clk_w_i);
      end
      // A second done would mean the mid-flight start was queued.
      wait_done(40, cyc, to);
      checks++; if (!to) begin errors++; $display("FAIL ignore_extra_done got done want none"); end
   endtask

   task automatic test_kill();
      int cyc;
      bit to;
      apply_stimulus(3'd5, 32'd100, 32'd7, 5'd3, 32'd14);
      repeat (19) @(negedge clk_w_i);
      kill_w_i = 1'b1;
      @(negedge clk_w_i);
      kill_w_i = 1'b0;
      checks++; if (busy_w_o !== 1'b0) begin errors++; $display("FAIL kill_busy got %b want 0", busy_w_o); end
      void'(sb.pop_back());
      wait_done(40, cyc, to);
      checks++; if (!to) begin errors++; $display("FAIL kill_done got done after %0d want none", cyc); end
      // kill wins over start in IDLE
      start_w_i = 1'b1; kill_w_i = 1'b1; op_w_i = 3'd0; src_a_w_i = 32'd2; src_b_w_i = 32'd3; rd_w_i = 5'd1;
      @(negedge clk_w_i);
      start_w_i = 1'b0; kill_w_i = 1'b0;
      checks++; if (busy_w_o !== 1'b0) begin errors++; $display("FAIL kill_idle_busy got %b want 0", busy_w_o); end
   endtask

   task automatic test_reset_midop();
      int cyc;
      bit to;
      apply_stimulus(3'd0, 32'd9, 32'd9, 5'd9, 32'd81);
      repeat (4) @(negedge clk_w_i);
      #2 res_w_i_l = 1'b0;
      #1;
      checks++; if (busy_w_o !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy_w_o); end
      checks++; if (wr_reg_w_o !== 5'd0) begin errors++; $display("FAIL midreset_wr_reg got %0d want 0", wr_reg_w_o); end
      checks++; if ({done_w_o, reg_wr_flag_w_o, result_w_o, wr_data_w_o} !== 66'h0) begin
         errors++; $display("FAIL midreset_outputs got done=%b flag=%b res=%h data=%h want 0", done_w_o, reg_wr_flag_w_o, result_w_o, wr_data_w_o);
      end
      void'(sb.pop_back());
      @(negedge clk_w_i);
      res_w_i_l = 1'b1;
      wait_done(40, cyc, to);
      checks++; if (!to) begin errors++; $display("FAIL midreset_done got done after %0d want none", cyc); end
   endtask

   // Random stream issued at the first IDLE cycle after each DONE.
   task automatic test_back_to_back();
      int          cyc;
      bit          to;
      exp_t        e;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int          lat;
      for (int n = 0; n < 150; n++) begin
         op  = 3'($urandom);
         a   = pick_operand();
         b   = pick_operand();
         rd  = 5'($urandom);
         lat = exp_latency(op, a, b);
         apply_stimulus(op, a, b, rd, model(op, a, b));
         wait_done(40, cyc, to);
         e = sb.pop_front();
         checks++;
         if (to) begin
            errors++; $display("FAIL rand_timeout op %0d a %h b %h no done", op, a, b);
            @(negedge clk_w_i);
         end else begin
            checks++; if (cyc !== lat) begin errors++; $display("FAIL rand_latency op %0d got %0d want %0d", op, cyc, lat); end
            checks++; if (result_w_o !== e.result) begin errors++; $display("FAIL rand_result op %0d a %h b %h got %h want %h", op, a, b, result_w_o, e.result); end
            checks++; if (wr_data_w_o !== e.result) begin errors++; $display("FAIL rand_wr_data op %0d got %h want %h", op, wr_data_w_o, e.result); end
            checks++; if (wr_reg_w_o !== e.rd) begin errors++; $display("FAIL rand_wr_reg got %0d want %0d", wr_reg_w_o, e.rd); end
            checks++; if (reg_wr_flag_w_o !== e.flag) begin errors++; $display("FAIL rand_flag got %b want %b", reg_wr_flag_w_o, e.flag); end
            @(negedge clk_w_i);
            checks++; if (busy_w_o !== 1'b0) begin errors++; $display("FAIL rand_busy_after got %b want 0", busy_w_o); end
         end
      end
      checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_ignore_start();
      test_kill();
      test_reset_midop();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
